// File: rtl/seg7_scan_driver_if.sv
// Display bus between a result source and seg7_scan_driver.
//   master : drives value/dp_in/digit_en/blank_lz, observes the display pins
//   slave  : the scan driver (consumes the request, drives the pins)
// Signals:
//   value     4*N_DIGITS packed nibbles, digit 0 in the low nibble
//   dp_in     per-digit decimal point request
//   digit_en  per-digit enable (0 = anode held inactive)
//   blank_lz  blank leading zeros
//   segments  {a,b,c,d,e,f,g}, a = MSB, polarity per ACTIVE_LOW
//   dp        decimal point of the scanned digit
//   anodes    one-hot digit select, polarity per ACTIVE_LOW
interface seg7_scan_driver_if #(
   parameter int N_DIGITS = 8
);
   logic [4*N_DIGITS-1:0] value;
   logic [N_DIGITS-1:0]   dp_in;
   logic [N_DIGITS-1:0]   digit_en;
   logic                  blank_lz;
   logic [6:0]            segments;
   logic                  dp;
   logic [N_DIGITS-1:0]   anodes;

   modport master (
      output value, dp_in, digit_en, blank_lz,
      input  segments, dp, anodes
   );

   modport slave (
      input  value, dp_in, digit_en, blank_lz,
      output segments, dp, anodes
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hexadecimal driver for N_DIGITS seven-segment digits.
// A prescaler holds each digit for COUNT_MAX cycles; the input request is
// snapshotted once per frame so a digit never tears mid-frame. Outputs are
// registered and XOR-inverted when ACTIVE_LOW = 1.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    seg7_scan_driver_if slave modport (request in, display pins out)
//
// state   | meaning
// --------+-------------------------------------------------------------
// RESET   | reset input high; register forced to LOAD, everything dark
// ST_LOAD | first cycle after release; snapshot loads on its closing edge
// ST_SCAN | steady scanning; snapshot reloads at each frame boundary
module seg7_scan_driver #(
   parameter int N_DIGITS   = 8,
   parameter int COUNT_MAX  = 100000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input logic               clk,
   input logic               reset,
   seg7_scan_driver_if.slave bus
);

   localparam int IDX_W = $clog2(N_DIGITS);
   localparam int PRE_W = $clog2(COUNT_MAX);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(COUNT_MAX - 1);

   typedef enum logic {
      ST_LOAD,
      ST_SCAN
   } state_t;

   state_t state_q, state_d;

   logic [PRE_W-1:0]      pre_q, pre_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [4*N_DIGITS-1:0] snap_q, snap_d;
   logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
   logic [N_DIGITS-1:0]   snap_en_q, snap_en_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [N_DIGITS-1:0]   an_q, an_d;

   logic                  load_first;
   logic                  tick;
   logic                  snap_load;

   logic [3:0]            nib;
   logic                  dig_en;
   logic                  dig_dp;
   logic                  blank;
   logic [N_DIGITS-1:0]   an_sel;
   logic [6:0]            seg_lit;

   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h7E;
         4'h1: s = 7'h30;
         4'h2: s = 7'h6D;
         4'h3: s = 7'h79;
         4'h4: s = 7'h33;
         4'h5: s = 7'h5B;
         4'h6: s = 7'h5F;
         4'h7: s = 7'h70;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h7B;
         4'hA: s = 7'h77;
         4'hB: s = 7'h1F;
         4'hC: s = 7'h4E;
         4'hD: s = 7'h3D;
         4'hE: s = 7'h4F;
         default: s = 7'h47;
      endcase
      return s;
   endfunction

   // FSM next state
   always_comb begin
      state_d    = state_q;
      load_first = 1'b0;
      case (state_q)
         ST_LOAD: begin
            load_first = 1'b1;
            state_d    = ST_SCAN;
         end
         ST_SCAN: state_d = ST_SCAN;
      endcase
   end

   // Prescaler, digit index and snapshot
   always_comb begin
      tick  = (pre_q == PRE_LAST);
      pre_d = tick ? '0 : pre_q + 1'b1;
      idx_d = idx_q;
      if (tick) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      // A tick on the last digit is the frame boundary: new data and idx=0
      // land on the same edge, so digit 0 of the next frame is already new.
      snap_load = load_first | (tick & (idx_q == IDX_LAST));
      snap_d    = snap_load ? bus.value    : snap_q;
      snap_dp_d = snap_load ? bus.dp_in    : snap_dp_q;
      snap_en_d = snap_load ? bus.digit_en : snap_en_q;
   end

   // Output decode for the digit currently indexed
   always_comb begin
      nib    = '0;
      dig_en = 1'b0;
      dig_dp = 1'b0;
      an_sel = '0;
      blank  = bus.blank_lz && (idx_q != '0);
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib       = snap_q[4*i +: 4];
            dig_en    = snap_en_q[i];
            dig_dp    = snap_dp_q[i];
            an_sel[i] = 1'b1;
         end
         // any nonzero digit at or above the current one cancels blanking
         if ((IDX_W'(i) >= idx_q) && (snap_q[4*i +: 4] != 4'h0)) begin
            blank = 1'b0;
         end
      end
      seg_lit = '0;
      if (dig_en && !blank) begin
         seg_lit = decode(nib);
      end
      seg_d = seg_lit ^ {7{ACTIVE_LOW}};
      dp_d  = (dig_en & dig_dp) ^ ACTIVE_LOW;
      an_d  = (dig_en ? an_sel : '0) ^ {N_DIGITS{ACTIVE_LOW}};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_LOAD;
         pre_q     <= '0;
         idx_q     <= '0;
         snap_q    <= '0;
         snap_dp_q <= '0;
         snap_en_q <= '0;
         seg_q     <= {7{ACTIVE_LOW}};
         dp_q      <= ACTIVE_LOW;
         an_q      <= {N_DIGITS{ACTIVE_LOW}};
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         idx_q     <= idx_d;
         snap_q    <= snap_d;
         snap_dp_q <= snap_dp_d;
         snap_en_q <= snap_en_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         an_q      <= an_d;
      end
   end

   assign bus.segments = seg_q;
   assign bus.dp       = dp_q;
   assign bus.anodes   = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

   localparam int N  = 4;
   localparam int CM = 4;

   logic clk;
   logic rst;

   seg7_scan_driver_if #(.N_DIGITS(N)) bus_if ();

   seg7_scan_driver #(
      .N_DIGITS  (N),
      .COUNT_MAX (CM),
      .ACTIVE_LOW(1'b1)
   ) dut (
      .clk  (clk),
      .reset(rst),
      .bus  (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Lit patterns from the glyph list (bit6 = a), before polarity
   localparam logic [6:0] GLYPH [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   // Hand-inverted codes for the glyph sweep
   localparam logic [6:0] SWEEP [16] = '{
      7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
      7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
   };

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural reference model -----------------
   // Edge k counts rising edges since reset release (E1 = 1). The digit
   // shown at Ek is the one indexed after E(k-1): ((k-1)/CM) mod N.
   // The request is captured at E1 and at every edge that is a multiple
   // of one frame (N*CM).
   function automatic logic [11:0] model_out(input int idx, input logic [15:0] v,
                                             input logic [3:0] d, input logic [3:0] en,
                                             input logic blz);
      logic [6:0] seg;
      logic       dpl;
      logic [3:0] an;
      int         nib;
      bit         blank;
      nib   = int'((v >> (4 * idx)) & 16'hF);
      blank = blz && (idx != 0) && ((v >> (4 * idx)) == 16'h0);
      seg = '0;
      dpl = 1'b0;
      an  = '0;
      if (en[idx]) begin
         seg = blank ? 7'h00 : GLYPH[nib];
         dpl = d[idx];
         an  = 4'(1 << idx);
      end
      return {~seg, ~dpl, ~an};
   endfunction

   int          mk = 0;
   logic [15:0] m_val = '0;
   logic [3:0]  m_dp = '0;
   logic [3:0]  m_en = '0;
   logic [11:0] m_exp;

   always @(posedge clk) begin
      if (rst) begin
         mk    = 0;
         m_val = '0;
         m_dp  = '0;
         m_en  = '0;
         m_exp = {7'h7F, 1'b1, 4'hF};
      end else begin
         mk++;
         if (mk == 1) m_exp = {7'h7F, 1'b1, 4'hF};
         else m_exp = model_out(((mk - 1) / CM) % N, m_val, m_dp, m_en, bus_if.blank_lz);
         if (mk == 1 || (mk % (N * CM)) == 0) begin
            m_val = bus_if.value;
            m_dp  = bus_if.dp_in;
            m_en  = bus_if.digit_en;
         end
      end
      #1;
      chk("model_seg", 16'(bus_if.segments), 16'(m_exp[11:5]));
      chk("model_dp",  16'(bus_if.dp),       16'(m_exp[4]));
      chk("model_an",  16'(bus_if.anodes),   16'(m_exp[3:0]));
   end

   // ---------------- directed helpers -----------------
   task automatic wait_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [15:0] v, input logic [3:0] d,
                           input logic [3:0] en, input logic blz);
      @(negedge clk);
      rst              = 1'b1;
      bus_if.value     = v;
      bus_if.dp_in     = d;
      bus_if.digit_en  = en;
      bus_if.blank_lz  = blz;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // {inputs, expected outputs per digit slot} -- digit d at [7d+:7], [4d+:4], [d]
   typedef struct {
      logic [15:0] val;
      logic [3:0]  dpi;
      logic [3:0]  en;
      logic        blz;
      logic [27:0] seg;
      logic [15:0] an;
      logic [3:0]  dp;
   } vec_t;

   vec_t vecs [7];

   initial begin
      vecs[0] = '{16'h1234, 4'h0, 4'hF, 1'b0, {7'h4F, 7'h12, 7'h06, 7'h4C}, 16'h7BDE, 4'hF};
      vecs[1] = '{16'h0050, 4'h0, 4'hF, 1'b1, {7'h7F, 7'h7F, 7'h24, 7'h01}, 16'h7BDE, 4'hF};
      vecs[2] = '{16'h0000, 4'h0, 4'hF, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 16'h7BDE, 4'hF};
      vecs[3] = '{16'h1234, 4'h1, 4'h5, 1'b0, {7'h7F, 7'h12, 7'h7F, 7'h4C}, 16'hFBFE, 4'hE};
      vecs[4] = '{16'h89AB, 4'hA, 4'hF, 1'b1, {7'h00, 7'h04, 7'h08, 7'h60}, 16'h7BDE, 4'h5};
      vecs[5] = '{16'hCDEF, 4'hF, 4'hF, 1'b0, {7'h31, 7'h42, 7'h30, 7'h38}, 16'h7BDE, 4'h0};
      vecs[6] = '{16'h0706, 4'h0, 4'hF, 1'b1, {7'h7F, 7'h0F, 7'h01, 7'h20}, 16'h7BDE, 4'hF};

      rst             = 1'b1;
      bus_if.value    = '0;
      bus_if.dp_in    = '0;
      bus_if.digit_en = '0;
      bus_if.blank_lz = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_seg", 16'(bus_if.segments), 16'h007F);
      chk("reset_an",  16'(bus_if.anodes),   16'h000F);
      chk("reset_dp",  16'(bus_if.dp),       16'h0001);

      // table: one frame after release, sample each digit slot
      for (int v = 0; v < 7; v++) begin
         do_reset(vecs[v].val, vecs[v].dpi, vecs[v].en, vecs[v].blz);
         for (int e = 1; e <= 14; e++) begin
            wait_edge();
            if (e == 1) begin
               chk("e1_dark_seg", 16'(bus_if.segments), 16'h007F);
               chk("e1_dark_an",  16'(bus_if.anodes),   16'h000F);
            end else if (((e - 2) % 4) == 0) begin
               chk("vec_seg", 16'(bus_if.segments), 16'(vecs[v].seg[7*((e-2)/4) +: 7]));
               chk("vec_an",  16'(bus_if.anodes),   16'(vecs[v].an[4*((e-2)/4) +: 4]));
               chk("vec_dp",  16'(bus_if.dp),       16'(vecs[v].dp[(e-2)/4]));
            end
         end
      end

      // glyph sweep: digit 0 steps 0..F, one value per frame
      do_reset(16'h0000, 4'h0, 4'hF, 1'b0);
      for (int k = 1; k <= 241; k++) begin
         wait_edge();
         if (k == 2 || (k >= 17 && (k % 16) == 1)) begin
            chk("sweep_seg", 16'(bus_if.segments), 16'(SWEEP[k / 16]));
            chk("sweep_an",  16'(bus_if.anodes),   16'h000E);
         end
         @(negedge clk);
         if ((k % 16) == 15) bus_if.value = 16'((k + 1) / 16);
      end

      // tearing: change request in the digit-2 slot
      do_reset(16'h1234, 4'h0, 4'hF, 1'b0);
      for (int k = 1; k <= 17; k++) begin
         wait_edge();
         if (k == 10) chk("tear_d2",  16'(bus_if.segments), 16'h0012);
         if (k == 13) chk("tear_d3",  16'(bus_if.segments), 16'h004F);
         if (k == 17) begin
            chk("tear_new_d0", 16'(bus_if.segments), 16'h0042);
            chk("tear_new_an", 16'(bus_if.anodes),   16'h000E);
         end
         @(negedge clk);
         if (k == 9) bus_if.value = 16'hABCD;
      end

      // mid-scan reset for one cycle
      do_reset(16'h1234, 4'h0, 4'hF, 1'b0);
      repeat (8) wait_edge();
      @(negedge clk);
      rst = 1'b1;
      wait_edge();
      chk("midrst_seg", 16'(bus_if.segments), 16'h007F);
      chk("midrst_an",  16'(bus_if.anodes),   16'h000F);
      @(negedge clk);
      rst = 1'b0;
      wait_edge();
      chk("midrst_e1_an", 16'(bus_if.anodes), 16'h000F);
      wait_edge();
      chk("midrst_e2_seg", 16'(bus_if.segments), 16'h004C);
      chk("midrst_e2_an",  16'(bus_if.anodes),   16'h000E);

      // randomized run, checked by the model every edge
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 5) == 0) begin
            logic [15:0] mask;
            for (int j = 0; j < 4; j++) mask[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'hF;
            bus_if.value = 16'($urandom) & mask;
         end
         if ($urandom_range(0, 9) == 0) bus_if.dp_in = 4'($urandom);
         if ($urandom_range(0, 9) == 0) bus_if.digit_en = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
         if ($urandom_range(0, 29) == 0) bus_if.blank_lz = 1'($urandom);
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
